// File: rtl/axi_lite_mem_slave_pkg.sv
// axi_lite_mem_slave_pkg: response codes and FSM state type for the AXI4-Lite memory slave
package axi_lite_mem_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    RD_RESP,
    WR_COLLECT,
    WR_MEM,
    WR_RESP
  } axi_slv_state_t;
endpackage

// File: rtl/axi_lite_mem_slave_bram_be.sv
// axi_lite_mem_slave_bram_be: single-port RAM, 1-cycle read latency, per-byte write enables
module axi_lite_mem_slave_bram_be #(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] = '0;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite slave over a byte-writable RAM, one transaction in flight
module axi_lite_mem_slave
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  axi_slv_state_t state_q;
  logic          aw_held_q, w_held_q, werr_q, rerr_q, rvalid_q, bvalid_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q, rdata_q;
  logic [3:0]    wstrb_q;
  logic [1:0]    rresp_q, bresp_q;
  logic [31:0]   roff, woff, ram_rdata;
  logic          rerr_d, werr_d, aw_hs, w_hs, aw_have, w_have;
  logic          unused_bits;
  assign roff   = axi_araddr - BASE_ADDR;
  assign woff   = axi_awaddr - BASE_ADDR;
  assign rerr_d = roff[31:AW+2] != '0;
  assign werr_d = woff[31:AW+2] != '0;
  assign unused_bits = ^{axi_arprot, axi_awprot, roff[1:0], woff[1:0]};
  assign axi_arready = state_q == IDLE;
  assign axi_awready = (state_q == IDLE && !axi_arvalid) || (state_q == WR_COLLECT && !aw_held_q);
  assign axi_wready  = (state_q == IDLE && !axi_arvalid) || (state_q == WR_COLLECT && !w_held_q);
  assign aw_hs   = axi_awvalid && axi_awready;
  assign w_hs    = axi_wvalid && axi_wready;
  assign aw_have = aw_hs || aw_held_q;
  assign w_have  = w_hs || w_held_q;
  assign axi_rdata  = rdata_q;
  assign axi_rresp  = rresp_q;
  assign axi_rvalid = rvalid_q;
  assign axi_bresp  = bresp_q;
  assign axi_bvalid = bvalid_q;
  axi_lite_mem_slave_bram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .we_i   ((state_q == WR_MEM && !werr_q) ? wstrb_q : 4'b0000),
    .addr_i ((state_q == IDLE) ? roff[AW+1:2] : waddr_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );
  // Transaction FSM: AW/W latching, RAM sequencing and registered R/B responses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      werr_q    <= 1'b0;
      rerr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        waddr_q   <= woff[AW+1:2];
        werr_q    <= werr_d;
        aw_held_q <= 1'b1;
      end
      if (w_hs) begin
        wdata_q  <= axi_wdata;
        wstrb_q  <= axi_wstrb;
        w_held_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (axi_arvalid) begin
            rerr_q  <= rerr_d;
            state_q <= RD_MEM;
          end else if (aw_hs || w_hs) state_q <= (aw_hs && w_hs) ? WR_MEM : WR_COLLECT;
        end
        RD_MEM: begin
          rdata_q  <= rerr_q ? '0 : ram_rdata;
          rresp_q  <= rerr_q ? RESP_SLVERR : RESP_OKAY;
          rvalid_q <= 1'b1;
          state_q  <= RD_RESP;
        end
        RD_RESP: begin
          if (axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WR_COLLECT: if (aw_have && w_have) state_q <= WR_MEM;
        WR_MEM: begin
          bresp_q   <= werr_q ? RESP_SLVERR : RESP_OKAY;
          bvalid_q  <= 1'b1;
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          state_q   <= WR_RESP;
        end
        WR_RESP: begin
          if (axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed vector table plus ordering, backpressure and reset sequences
module tb_axi_lite_mem_slave;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] axi_araddr = '0, axi_awaddr = '0, axi_wdata = '0;
  logic        axi_arvalid = 1'b0, axi_awvalid = 1'b0, axi_wvalid = 1'b0;
  logic        axi_rready = 1'b0, axi_bready = 1'b0;
  logic [3:0]  axi_wstrb = '0;
  logic [2:0]  axi_arprot = '0, axi_awprot = '0;
  logic        axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp, axi_bresp;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_lite_mem_slave dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;
  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output logic ok);
    logic aw_go, w_go, b_go;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    ok = 1'b0; resp = 2'bxx;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      aw_go = axi_awvalid && axi_awready;
      w_go  = axi_wvalid && axi_wready;
      b_go  = axi_bvalid && axi_bready;
      if (b_go) resp = axi_bresp;
      @(posedge clk); #1;
      if (aw_go) axi_awvalid = 1'b0;
      if (w_go) axi_wvalid = 1'b0;
      if (b_go) ok = 1'b1;
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                    output int lat, output logic [1:0] side, output logic ok);
    logic ar_go, r_go;
    int hs;
    axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1;
    ok = 1'b0; hs = -1; lat = -1; side = 2'bxx; data = 'x; resp = 2'bxx;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ar_go = axi_arvalid && axi_arready;
      r_go  = axi_rvalid && axi_rready;
      if (ar_go) begin
        hs = n;
        side = {axi_awready, axi_wready};
      end
      if (r_go) begin
        data = axi_rdata;
        resp = axi_rresp;
        lat = n - hs;
      end
      @(posedge clk); #1;
      if (ar_go) axi_arvalid = 1'b0;
      if (r_go) ok = 1'b1;
    end
    axi_arvalid = 1'b0; axi_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d, held;
    logic [1:0]  r, side;
    logic        ok, got;
    int          lat, pulses;
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 2'b00};
    vt[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 2'b00};
    vt[3]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEAA, 4'h0, 2'b00};
    vt[4]  = '{1'b1, 32'h0000_0014, 32'h1122_3344, 4'hF, 2'b00};
    vt[5]  = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'hA, 2'b00};
    vt[6]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 2'b00};
    vt[7]  = '{1'b0, 32'h0000_0014, 32'hAA22_CC44, 4'h0, 2'b00};
    vt[8]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 2'b00};
    vt[9]  = '{1'b0, 32'h0000_0003, 32'hCAFE_F00D, 4'h0, 2'b00};
    vt[10] = '{1'b0, 32'h0000_4000, 32'h0000_0000, 4'h0, 2'b10};
    vt[11] = '{1'b1, 32'h0000_4000, 32'h1234_5678, 4'hF, 2'b10};
    vt[12] = '{1'b0, 32'h0000_0000, 32'hCAFE_F00D, 4'h0, 2'b00};
    vt[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 2'b10};
    vt[14] = '{1'b1, 32'h0000_3FFC, 32'h8765_4321, 4'hF, 2'b00};
    vt[15] = '{1'b0, 32'h0000_3FFC, 32'h8765_4321, 4'h0, 2'b00};
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_rvalid", {31'b0, axi_rvalid}, 32'd0);
    chk("reset_bvalid", {31'b0, axi_bvalid}, 32'd0);
    chk("reset_rdata", axi_rdata, 32'd0);
    chk("reset_resp", {28'b0, axi_rresp, axi_bresp}, 32'd0);
    chk("reset_arready", {31'b0, axi_arready}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) begin
        wr(vt[i].addr, vt[i].data, vt[i].strb, r, ok);
        chk($sformatf("vec%0d_wr_done", i), {31'b0, ok}, 32'd1);
        chk($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, vt[i].resp});
      end else begin
        rd(vt[i].addr, d, r, lat, side, ok);
        chk($sformatf("vec%0d_rd_done", i), {31'b0, ok}, 32'd1);
        chk($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, vt[i].resp});
        chk($sformatf("vec%0d_rdata", i), d, vt[i].data);
        chk($sformatf("vec%0d_rlat", i), lat, 32'd2);
      end
    end
    axi_wdata = 32'h5A5A_1234; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", {31'b0, axi_wready}, 32'd1);
    @(posedge clk); #1;
    axi_wvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_collect_rdy", {30'b0, axi_awready, axi_wready}, 32'b10);
    @(posedge clk); #1;
    axi_awaddr = 32'h0000_0020; axi_awvalid = 1'b1; axi_bready = 1'b1;
    @(negedge clk);
    chk("wfirst_awready", {31'b0, axi_awready}, 32'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    pulses = 0; r = 2'bxx;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (axi_bvalid) begin
        pulses++;
        r = axi_bresp;
      end
    end
    axi_bready = 1'b0;
    @(posedge clk); #1;
    chk("wfirst_bpulses", pulses, 32'd1);
    chk("wfirst_bresp", {30'b0, r}, 32'd0);
    rd(32'h0000_0020, d, r, lat, side, ok);
    chk("wfirst_readback", d, 32'h5A5A_1234);
    axi_awaddr = 32'h0000_0024; axi_wdata = 32'h0BAD_CAFE; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    rd(32'h0000_0010, d, r, lat, side, ok);
    chk("tie_rd_done", {31'b0, ok}, 32'd1);
    chk("tie_aw_w_ready", {30'b0, side}, 32'd0);
    chk("tie_rdata", d, 32'hDEAD_BEAA);
    chk("tie_no_b_yet", {31'b0, axi_bvalid}, 32'd0);
    wr(32'h0000_0024, 32'h0BAD_CAFE, 4'hF, r, ok);
    chk("tie_wr_done", {31'b0, ok}, 32'd1);
    chk("tie_bresp", {30'b0, r}, 32'd0);
    rd(32'h0000_0024, d, r, lat, side, ok);
    chk("tie_readback", d, 32'h0BAD_CAFE);
    axi_araddr = 32'h0000_0010; axi_arvalid = 1'b1;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = axi_rvalid;
    end
    chk("bp_rvalid_seen", {31'b0, got}, 32'd1);
    held = axi_rdata;
    chk("bp_rdata", held, 32'hDEAD_BEAA);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", n), {axi_rvalid, axi_rdata[30:0]}, {1'b1, held[30:0]});
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_rvalid", {31'b0, axi_rvalid}, 32'd0);
    rstn = 1'b1;
    rd(32'h0000_0010, d, r, lat, side, ok);
    chk("rst_ram_kept", d, 32'hDEAD_BEAA);
    rd(32'h0000_0024, d, r, lat, side, ok);
    chk("rst_ram_kept2", d, 32'h0BAD_CAFE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
